// File: rtl/apb_arb_pkg.sv
// Shared types and the arbitration decision for the two-requester APB arbiter.
// The pick function is kept here so it can be reused by any other APB arbiter.
package apb_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  // Returns the index of the requester to serve; only meaningful when req != 0.
  function automatic logic arb_pick(input logic [1:0] req,
                                    input logic       last_grant,
                                    input logic       round_robin);
    logic grant;
    grant = 1'b0;
    if (req == 2'b10) begin
      grant = 1'b1;
    end else if (req == 2'b11) begin
      grant = round_robin ? ~last_grant : 1'b0;
    end
    return grant;
  endfunction

endpackage

// File: rtl/apb_arbiter.sv
// Shares one APB completer between two APB requesters (core s0, secondary master s1).
// One transfer at a time is replayed on the completer port; the response goes to the winner only.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              s0_psel,
  input  logic              s0_penable,
  input  logic [ADDR_W-1:0] s0_paddr,
  input  logic              s0_pwrite,
  input  logic [DATA_W-1:0] s0_pwdata,
  input  logic [STRB_W-1:0] s0_pwstrb,
  output logic              s0_pready,
  output logic [DATA_W-1:0] s0_prdata,
  output logic              s0_pslverr,

  input  logic              s1_psel,
  input  logic              s1_penable,
  input  logic [ADDR_W-1:0] s1_paddr,
  input  logic              s1_pwrite,
  input  logic [DATA_W-1:0] s1_pwdata,
  input  logic [STRB_W-1:0] s1_pwstrb,
  output logic              s1_pready,
  output logic [DATA_W-1:0] s1_prdata,
  output logic              s1_pslverr,

  output logic              m_psel,
  output logic              m_penable,
  output logic [ADDR_W-1:0] m_paddr,
  output logic              m_pwrite,
  output logic [DATA_W-1:0] m_pwdata,
  output logic [STRB_W-1:0] m_pwstrb,
  input  logic              m_pready,
  input  logic [DATA_W-1:0] m_prdata,
  input  logic              m_pslverr
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_grant;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pwstrb;

  logic [1:0]        w_req;
  logic              w_pick;
  logic              w_take;
  logic              w_done;
  logic              w_gnt_psel;
  logic              w_gnt_penable;

  assign w_req         = {s1_psel, s0_psel};
  assign w_pick        = arb_pick(w_req, r_last_grant, ROUND_ROBIN);
  assign w_take        = (r_state == ARB_IDLE) && (|w_req);
  assign w_gnt_psel    = r_grant ? s1_psel    : s0_psel;
  assign w_gnt_penable = r_grant ? s1_penable : s0_penable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:   if (|w_req)   w_next = ARB_SETUP;
      ARB_SETUP:                w_next = ARB_ACCESS;
      ARB_ACCESS: if (m_pready) w_next = ARB_IDLE;
      default:                  w_next = ARB_IDLE;
    endcase
  end

  // Grant and the winner's request are captured once, so later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_pwstrb     <= '0;
    end else if (w_take) begin
      r_grant      <= w_pick;
      r_last_grant <= w_pick;
      r_paddr      <= w_pick ? s1_paddr  : s0_paddr;
      r_pwrite     <= w_pick ? s1_pwrite : s0_pwrite;
      r_pwdata     <= w_pick ? s1_pwdata : s0_pwdata;
      r_pwstrb     <= w_pick ? s1_pwstrb : s0_pwstrb;
    end
  end

  assign m_paddr  = r_paddr;
  assign m_pwrite = r_pwrite;
  assign m_pwdata = r_pwdata;
  assign m_pwstrb = r_pwstrb;

  always_comb begin
    m_psel     = 1'b0;
    m_penable  = 1'b0;
    w_done     = 1'b0;
    s0_pready  = 1'b0;
    s0_prdata  = '0;
    s0_pslverr = 1'b0;
    s1_pready  = 1'b0;
    s1_prdata  = '0;
    s1_pslverr = 1'b0;
    case (r_state)
      ARB_SETUP: m_psel = 1'b1;
      ARB_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        w_done    = m_pready;
      end
      default: ;
    endcase
    // Response reaches only the granted requester, and only in the completion cycle.
    if (w_done) begin
      if (r_grant) begin
        s1_pready  = 1'b1;
        s1_prdata  = m_prdata;
        s1_pslverr = m_pslverr;
      end else begin
        s0_pready  = 1'b1;
        s0_prdata  = m_prdata;
        s0_pslverr = m_pslverr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (r_state != ARB_IDLE)) begin
      assert (w_gnt_psel && w_gnt_penable)
        else $error("apb_arbiter: requester s%0d abandoned its transfer before pready", r_grant);
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: requester/completer models drive both masters,
// a queue holds the expected completer transfers in arbitration order.
module tb_apb_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel_fp;
  logic        rst_rr;
  logic        rst_fp;
  logic [1:0]  s_psel;
  logic [1:0]  s_pen;
  logic [1:0]  s_wr;
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_strb  [2];
  logic        c_pready;
  logic [31:0] c_prdata;
  logic        c_pslverr;

  wire [70:0] rr_mbus;
  wire [70:0] fp_mbus;
  wire [67:0] rr_sresp;
  wire [67:0] fp_sresp;
  logic [70:0] o_mbus;
  logic [67:0] o_sresp;

  assign rst_rr  = rst | sel_fp;
  assign rst_fp  = rst | ~sel_fp;
  assign o_mbus  = sel_fp ? fp_mbus  : rr_mbus;
  assign o_sresp = sel_fp ? fp_sresp : rr_sresp;

  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [3:0]  m_pwstrb;
  logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
  logic [31:0] s0_prdata, s1_prdata;
  assign {m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pwstrb} = o_mbus;
  assign {s1_pready, s1_prdata, s1_pslverr, s0_pready, s0_prdata, s0_pslverr} = o_sresp;

  apb_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst_rr),
    .s0_psel(s_psel[0]), .s0_penable(s_pen[0]), .s0_paddr(s_addr[0]), .s0_pwrite(s_wr[0]),
    .s0_pwdata(s_wdata[0]), .s0_pwstrb(s_strb[0]),
    .s0_pready(rr_sresp[33]), .s0_prdata(rr_sresp[32:1]), .s0_pslverr(rr_sresp[0]),
    .s1_psel(s_psel[1]), .s1_penable(s_pen[1]), .s1_paddr(s_addr[1]), .s1_pwrite(s_wr[1]),
    .s1_pwdata(s_wdata[1]), .s1_pwstrb(s_strb[1]),
    .s1_pready(rr_sresp[67]), .s1_prdata(rr_sresp[66:35]), .s1_pslverr(rr_sresp[34]),
    .m_psel(rr_mbus[70]), .m_penable(rr_mbus[69]), .m_paddr(rr_mbus[68:37]), .m_pwrite(rr_mbus[36]),
    .m_pwdata(rr_mbus[35:4]), .m_pwstrb(rr_mbus[3:0]),
    .m_pready(c_pready), .m_prdata(c_prdata), .m_pslverr(c_pslverr)
  );

  apb_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst(rst_fp),
    .s0_psel(s_psel[0]), .s0_penable(s_pen[0]), .s0_paddr(s_addr[0]), .s0_pwrite(s_wr[0]),
    .s0_pwdata(s_wdata[0]), .s0_pwstrb(s_strb[0]),
    .s0_pready(fp_sresp[33]), .s0_prdata(fp_sresp[32:1]), .s0_pslverr(fp_sresp[0]),
    .s1_psel(s_psel[1]), .s1_penable(s_pen[1]), .s1_paddr(s_addr[1]), .s1_pwrite(s_wr[1]),
    .s1_pwdata(s_wdata[1]), .s1_pwstrb(s_strb[1]),
    .s1_pready(fp_sresp[67]), .s1_prdata(fp_sresp[66:35]), .s1_pslverr(fp_sresp[34]),
    .m_psel(fp_mbus[70]), .m_penable(fp_mbus[69]), .m_paddr(fp_mbus[68:37]), .m_pwrite(fp_mbus[36]),
    .m_pwdata(fp_mbus[35:4]), .m_pwstrb(fp_mbus[3:0]),
    .m_pready(c_pready), .m_prdata(c_prdata), .m_pslverr(c_pslverr)
  );

  txn_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_left [2];
  int         rdy_cnt [2];
  int         err_cnt [2];
  int         busy;
  int         wcnt;
  int         wait_n;
  logic [1:0] prev_rdy;
  logic       prev_done;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    txn_t t;
    t.id = id; t.addr = addr; t.wr = wr; t.wdata = wdata; t.strb = strb;
    sb.push_back(t);
  endtask

  // Requester i starts n back-to-back transfers; each next one is at addr+4, wdata+0x11.
  task automatic start(input int i, input int n, input logic [31:0] addr, input logic wr,
                       input logic [3:0] strb, input logic [31:0] wdata);
    s_psel[i]  = 1'b1;
    s_pen[i]   = 1'b0;
    s_addr[i]  = addr;
    s_wr[i]    = wr;
    s_strb[i]  = strb;
    s_wdata[i] = wdata;
    n_left[i]  = n;
    for (int k = 0; k < n; k++) push(1'(i), addr + 32'(4 * k), wr, wdata + 32'(17 * k), strb);
  endtask

  task automatic step();
    logic        cur_done;
    logic [67:0] exp_resp;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (s_psel[i]) begin
        if (prev_rdy[i]) begin
          n_left[i]--;
          if (n_left[i] > 0) begin
            s_addr[i]  = s_addr[i] + 32'd4;
            s_wdata[i] = s_wdata[i] + 32'h11;
            s_pen[i]   = 1'b0;
          end else begin
            s_psel[i] = 1'b0;
            s_pen[i]  = 1'b0;
          end
        end else begin
          s_pen[i] = 1'b1;
        end
      end
    end
    if (m_psel && m_penable) begin
      c_pready = (wcnt >= wait_n);
      wcnt++;
    end else begin
      c_pready = 1'b0;
      wcnt     = 0;
    end
    #1;
    cur_done = m_psel && m_penable && c_pready;
    exp_resp = '0;
    if (prev_done) check("idle_gap", m_psel, 1'b0);
    if (sb.size() == 0) begin
      check("no_xfer", m_psel, 1'b0);
    end else if (m_psel) begin
      busy++;
      check("m_capture", {m_paddr, m_pwrite, m_pwdata, m_pwstrb},
            {sb[0].addr, sb[0].wr, sb[0].wdata, sb[0].strb});
      if (cur_done) begin
        if (sb[0].id) exp_resp = {1'b1, c_prdata, c_pslverr, 34'd0};
        else          exp_resp = {34'd0, 1'b1, c_prdata, c_pslverr};
      end
    end
    check("s_resp", o_sresp, exp_resp);
    if (cur_done && (sb.size() > 0)) void'(sb.pop_front());
    rdy_cnt[0] += int'(s0_pready);
    rdy_cnt[1] += int'(s1_pready);
    err_cnt[0] += int'(s0_pslverr);
    err_cnt[1] += int'(s1_pslverr);
    prev_done = cur_done;
    prev_rdy  = {s1_pready, s0_pready};
  endtask

  task automatic run_until_empty(input string tag, input int max_cycles);
    int k;
    k = 0;
    while ((sb.size() > 0) && (k < max_cycles)) begin
      step();
      k++;
    end
    check(tag, sb.size(), 0);
    step();
    step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_psel   = '0;
    s_pen    = '0;
    n_left   = '{0, 0};
    c_pready = 1'b0;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel_fp = 1'b0;
    s_psel = '0; s_pen = '0; s_wr = '0;
    s_addr = '{32'd0, 32'd0}; s_wdata = '{32'd0, 32'd0}; s_strb = '{4'd0, 4'd0};
    c_pready = 1'b0; c_prdata = 32'd0; c_pslverr = 1'b0;
    n_left = '{0, 0}; rdy_cnt = '{0, 0}; err_cnt = '{0, 0};
    busy = 0; wcnt = 0; wait_n = 0; prev_rdy = '0; prev_done = 1'b0;

    do_reset();
    check("rst_mbus", o_mbus, 71'd0);
    check("rst_sresp", o_sresp, 68'd0);

    // Single zero-wait s0 read: SETUP at N+1, ACCESS and pready at N+2.
    c_prdata = 32'hDEADBEEF; c_pslverr = 1'b0; wait_n = 0;
    rdy_cnt = '{0, 0};
    start(0, 1, 32'h100, 1'b0, 4'hF, 32'h0);
    step();
    check("t1_setup", {m_psel, m_penable}, 2'b10);
    step();
    check("t1_access", {m_psel, m_penable, s0_pready}, 3'b111);
    check("t1_rdata", s0_prdata, 32'hDEADBEEF);
    run_until_empty("t1_drain", 10);
    check("t1_s1_rdy", rdy_cnt[1], 0);

    // s1 write with two wait states: four cycles on the completer, one pready.
    c_prdata = 32'h5555AAAA; wait_n = 2; busy = 0; rdy_cnt = '{0, 0};
    start(1, 1, 32'h200, 1'b1, 4'b0011, 32'h12345678);
    run_until_empty("t2_drain", 20);
    check("t2_busy", busy, 4);
    check("t2_rdy", {rdy_cnt[1], rdy_cnt[0]}, {32'd1, 32'd0});

    // Round-robin contention, both holding psel for four transfers each.
    do_reset();
    c_prdata = 32'h0BADF00D; wait_n = 0; rdy_cnt = '{0, 0};
    start(0, 4, 32'h1000, 1'b1, 4'hF, 32'hA0000000);
    start(1, 4, 32'h2000, 1'b0, 4'h3, 32'hB0000000);
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 32'h1000 + 32'(4 * k), 1'b1, 32'hA0000000 + 32'(17 * k), 4'hF);
      push(1'b1, 32'h2000 + 32'(4 * k), 1'b0, 32'hB0000000 + 32'(17 * k), 4'h3);
    end
    run_until_empty("t3_drain", 100);
    check("t3_rdy", {rdy_cnt[1], rdy_cnt[0]}, {32'd4, 32'd4});

    // Fixed priority: s0 drains all four before s1 gets the completer.
    sel_fp = 1'b1;
    do_reset();
    start(0, 4, 32'h1000, 1'b1, 4'hF, 32'hA0000000);
    start(1, 4, 32'h2000, 1'b0, 4'h3, 32'hB0000000);
    run_until_empty("t4_drain", 100);
    sel_fp = 1'b0;

    // Reset while stuck in ACCESS, after s0 was the last grant.
    do_reset();
    wait_n = 1000;
    start(0, 1, 32'h300, 1'b0, 4'hF, 32'h0);
    step();
    step();
    step();
    check("t5_stuck", {m_psel, m_penable, s0_pready}, 3'b110);
    rst = 1'b1; s_psel = '0; s_pen = '0; n_left = '{0, 0};
    sb.delete();
    step();
    check("t5_after_rst", {m_psel, m_penable, s0_pready, s1_pready}, 4'b0000);
    rst = 1'b0; wait_n = 0;
    start(0, 1, 32'h500, 1'b1, 4'h1, 32'h11110000);
    start(1, 1, 32'h600, 1'b1, 4'h2, 32'h22220000);
    run_until_empty("t5_drain", 30);

    // Completer error on an s1 read reaches s1 only, in its completion cycle.
    c_pslverr = 1'b1; c_prdata = 32'h600DCAFE; wait_n = 1; err_cnt = '{0, 0};
    start(1, 1, 32'h400, 1'b0, 4'hF, 32'h0);
    run_until_empty("t6_drain", 20);
    check("t6_err", {err_cnt[1], err_cnt[0]}, {32'd1, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
